// File: rtl/jtag_reg_bridge_pkg.sv
// Shared types, address constants and control-field offsets for the JTAG register bridge.
package jtag_reg_bridge_pkg;

    typedef logic [7:0] addr_t;

    localparam addr_t ADDR_ZERO    = 8'h00;
    localparam addr_t ADDR_ID      = 8'h01;
    localparam addr_t ADDR_RO_BASE = 8'h02;
    localparam addr_t ADDR_ERR     = 8'hFE;

    // Control fields are packed from the MSB of tcr downwards: addr[7:0], wr, autoinc.
    function automatic int addr_msb(input int ctrl_w);
        return ctrl_w - 1;
    endfunction

    function automatic int wr_bit(input int ctrl_w);
        return ctrl_w - 9;
    endfunction

    function automatic int autoinc_bit(input int ctrl_w);
        return ctrl_w - 10;
    endfunction

endpackage

// File: rtl/jtag_reg_bridge_if.sv
// JTAG-side signal bundle of the register bridge; master is the TAP side, slave the bridge.
interface jtag_reg_bridge_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 32
);
    logic              update_dr_i;
    logic              capture_dr_i;
    logic              sel_i;
    logic [CTRL_W-1:0] tcr_i;
    logic [DATA_W-1:0] shift_data_i;
    logic [DATA_W-1:0] shift_data_o;

    modport master (
        output update_dr_i, capture_dr_i, sel_i, tcr_i, shift_data_i,
        input  shift_data_o
    );

    modport slave (
        input  update_dr_i, capture_dr_i, sel_i, tcr_i, shift_data_i,
        output shift_data_o
    );
endinterface

// File: rtl/jtag_reg_bridge_pulse_sync.sv
// jtag_pulse_sync: 2-flop synchroniser plus registered rising-edge detect.
// A rising input edge becomes a single clk-wide pulse three clk cycles later.
module jtag_pulse_sync (
    input  logic clk,
    input  logic trst,
    input  logic async_i,
    output logic pulse_o
);
    logic sync1, sync2, sync3;

    always_ff @(posedge clk or posedge trst) begin
        if (trst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync3   <= 1'b0;
            pulse_o <= 1'b0;
        end else begin
            sync1   <= async_i;
            sync2   <= sync1;
            sync3   <= sync2;
            pulse_o <= sync2 & ~sync3;
        end
    end
endmodule

// File: rtl/jtag_reg_bridge.sv
// JTAG-to-fabric register bridge: ID, RO and RW words plus a clear-on-read error counter.
// Optional address auto-increment pointer enabled by defining JTAG_REG_BRIDGE_AUTOINC_EN.
module jtag_reg_bridge
    import jtag_reg_bridge_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                CTRL_W    = 32,
    parameter int                NUM_RO    = 4,
    parameter int                NUM_RW    = 4,
    parameter logic [DATA_W-1:0] ID_VALUE  = 'hDEAD_BEEF,
    parameter logic [DATA_W-1:0] RW_RESET  = '0,
    parameter logic [DATA_W-1:0] BAD_VALUE = 'hBEEF_BEEF,
    parameter int                ERR_W     = 8
) (
    input  logic                     clk,
    input  logic                     trst,
    jtag_reg_bridge_if.slave         jtag,
    input  logic [NUM_RO*DATA_W-1:0] ro_data_i,
    output logic [NUM_RW*DATA_W-1:0] rw_data_o,
    output logic [NUM_RW-1:0]        wr_strobe_o,
    output logic                     err_o
);
    localparam int ADDR_MSB = addr_msb(CTRL_W);
    localparam int WR_BIT   = wr_bit(CTRL_W);
    localparam int RO_BASE  = int'(ADDR_RO_BASE);
    localparam int RW_BASE  = RO_BASE + NUM_RO;

    logic upd_p, cap_p;

    jtag_pulse_sync u_upd_sync (
        .clk     (clk),
        .trst    (trst),
        .async_i (jtag.update_dr_i),
        .pulse_o (upd_p)
    );

    jtag_pulse_sync u_cap_sync (
        .clk     (clk),
        .trst    (trst),
        .async_i (jtag.capture_dr_i),
        .pulse_o (cap_p)
    );

    addr_t tcr_addr, eff_addr;
    logic  tcr_wr;
    logic  unused_tcr;

    assign tcr_addr   = jtag.tcr_i[ADDR_MSB -: 8];
    assign tcr_wr     = jtag.tcr_i[WR_BIT];
    assign unused_tcr = ^jtag.tcr_i;

`ifdef JTAG_REG_BRIDGE_AUTOINC_EN
    localparam int AUTOINC_BIT = autoinc_bit(CTRL_W);

    addr_t ptr, last_addr, ptr_eff;
    logic  tcr_autoinc;

    assign tcr_autoinc = jtag.tcr_i[AUTOINC_BIT];
    // A changed base address restarts the burst at offset 0 for this very access.
    assign ptr_eff  = (tcr_autoinc && (tcr_addr == last_addr)) ? ptr : '0;
    assign eff_addr = tcr_addr + ptr_eff;

    always_ff @(posedge clk or posedge trst) begin
        if (trst) begin
            ptr       <= '0;
            last_addr <= '0;
        end else if (upd_p) begin
            last_addr <= tcr_addr;
            ptr       <= (jtag.sel_i && tcr_autoinc) ? ptr_eff + 8'd1 : ptr_eff;
        end
    end
`else
    assign eff_addr = tcr_addr;
`endif

    logic [NUM_RW*DATA_W-1:0] rw_q;
    logic [ERR_W-1:0]         err_cnt;
    logic [DATA_W-1:0]        rd_mux;
    logic [NUM_RW-1:0]        wr_hit;
    logic                     do_write, err_inc, clr_set, clr_pend;

    assign rw_data_o = rw_q;
    assign err_o     = |err_cnt;

    always_comb begin
        rd_mux = BAD_VALUE;
        wr_hit = '0;
        if (eff_addr == ADDR_ZERO) rd_mux = '0;
        if (eff_addr == ADDR_ID)   rd_mux = ID_VALUE;
        if (eff_addr == ADDR_ERR)  rd_mux = DATA_W'(err_cnt);
        for (int k = 0; k < NUM_RO; k++) begin
            if (eff_addr == addr_t'(RO_BASE + k)) rd_mux = ro_data_i[k*DATA_W +: DATA_W];
        end
        for (int k = 0; k < NUM_RW; k++) begin
            if (eff_addr == addr_t'(RW_BASE + k)) begin
                rd_mux    = rw_q[k*DATA_W +: DATA_W];
                wr_hit[k] = 1'b1;
            end
        end
    end

    assign do_write = upd_p && jtag.sel_i && tcr_wr;
    assign err_inc  = do_write && (wr_hit == '0) && (eff_addr != ADDR_ERR);
    assign clr_set  = cap_p && jtag.sel_i && (eff_addr == ADDR_ERR);

    // Clear is delayed a clk so the captured word always holds the pre-clear count.
    always_ff @(posedge clk or posedge trst) begin
        if (trst) begin
            jtag.shift_data_o <= '0;
            wr_strobe_o       <= '0;
            rw_q              <= {NUM_RW{RW_RESET}};
            err_cnt           <= '0;
            clr_pend          <= 1'b0;
        end else begin
            jtag.shift_data_o <= rd_mux;
            wr_strobe_o       <= do_write ? wr_hit : '0;
            clr_pend          <= clr_set;
            for (int k = 0; k < NUM_RW; k++) begin
                if (do_write && wr_hit[k]) rw_q[k*DATA_W +: DATA_W] <= jtag.shift_data_i;
            end
            if (clr_pend)
                err_cnt <= '0;
            else if (err_inc && !(&err_cnt))
                err_cnt <= err_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_jtag_reg_bridge.sv
// Randomised scoreboard bench for jtag_reg_bridge; captures and write strobes are
// checked by monitors against a word-level model of the register map.
module tb_jtag_reg_bridge;
    localparam int DATA_W = 32;
    localparam int CTRL_W = 32;
    localparam int NUM_RO = 4;
    localparam int NUM_RW = 4;
    localparam int ERR_W  = 8;
    localparam int RW_LO  = 2 + NUM_RO;

    logic clk = 1'b0;
    logic trst = 1'b1;
    always #5 clk = ~clk;

    jtag_reg_bridge_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) jtag ();

    logic [NUM_RO*DATA_W-1:0] ro_data;
    logic [NUM_RW*DATA_W-1:0] rw_data;
    logic [NUM_RW-1:0]        wr_strobe;
    logic                     err;

    jtag_reg_bridge #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .NUM_RO(NUM_RO), .NUM_RW(NUM_RW),
        .ID_VALUE(32'hDEAD_BEEF), .RW_RESET(32'h0), .BAD_VALUE(32'hBEEF_BEEF), .ERR_W(ERR_W)
    ) dut (
        .clk         (clk),
        .trst        (trst),
        .jtag        (jtag),
        .ro_data_i   (ro_data),
        .rw_data_o   (rw_data),
        .wr_strobe_o (wr_strobe),
        .err_o       (err)
    );

    typedef struct {
        int          idx;
        logic [31:0] data;
    } wr_exp_t;

    wr_exp_t     wr_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] m_ro[NUM_RO];
    logic [31:0] m_rw[NUM_RW];
    int          m_err;
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic [31:0] model_read(input int a);
        if (a == 0) return 32'h0;
        if (a == 1) return 32'hDEAD_BEEF;
        if (a >= 2 && a < RW_LO) return m_ro[a-2];
        if (a >= RW_LO && a < RW_LO + NUM_RW) return m_rw[a-RW_LO];
        if (a == 254) return 32'(m_err);
        return 32'hBEEF_BEEF;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic report_unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: DUT event with no expected entry", name);
    endtask

    initial begin : capture_monitor
        forever begin
            @(posedge jtag.capture_dr_i);
            if (rd_q.size() == 0) report_unexpected("capture_read");
            else check_output("capture_read", jtag.shift_data_o, rd_q.pop_front());
        end
    end

    initial begin : strobe_monitor
        wr_exp_t e;
        forever begin
            @(negedge clk);
            if (trst === 1'b0 && wr_strobe !== '0) begin
                if (wr_q.size() == 0) report_unexpected("wr_strobe");
                else begin
                    e = wr_q.pop_front();
                    check_output("wr_strobe", 32'(wr_strobe), 32'(1) << e.idx);
                    check_output("rw_word", rw_data[e.idx*DATA_W +: DATA_W], e.data);
                end
            end
        end
    end

    task automatic set_tcr(input int addr, input logic wr, input logic autoinc);
        jtag.tcr_i = {8'(addr), wr, autoinc, 22'($urandom)};
    endtask

    task automatic apply_stimulus_write(input int addr, input logic [31:0] data,
                                        input logic sel, input logic wr, input logic autoinc);
        @(negedge clk);
        set_tcr(addr, wr, autoinc);
        jtag.sel_i        = sel;
        jtag.shift_data_i = data;
        if (sel && wr) begin
            if (addr >= RW_LO && addr < RW_LO + NUM_RW) begin
                m_rw[addr-RW_LO] = data;
                wr_q.push_back('{idx: addr - RW_LO, data: data});
            end else if (addr != 254 && m_err < 255) begin
                m_err++;
            end
        end
        jtag.update_dr_i = 1'b1;
        repeat (4) @(negedge clk);
        jtag.update_dr_i = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic apply_stimulus_read(input int addr, input logic sel);
        @(negedge clk);
        set_tcr(addr, 1'b0, 1'b0);
        jtag.sel_i = sel;
        repeat (2) @(negedge clk);
        rd_q.push_back(model_read(addr));
        if (sel && addr == 254) m_err = 0;
        jtag.capture_dr_i = 1'b1;
        repeat (4) @(negedge clk);
        jtag.capture_dr_i = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    function automatic int pick_addr();
        case ($urandom_range(0, 7))
            0:       return 0;
            1:       return 1;
            2:       return int'($urandom_range(2, RW_LO - 1));
            3, 4:    return int'($urandom_range(RW_LO, RW_LO + NUM_RW - 1));
            5:       return 254;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        jtag.update_dr_i  = 1'b0;
        jtag.capture_dr_i = 1'b0;
        jtag.sel_i        = 1'b0;
        jtag.tcr_i        = '0;
        jtag.shift_data_i = '0;
        for (int k = 0; k < NUM_RO; k++) m_ro[k] = $urandom;
        m_ro[2] = 32'hA5A5_0003;
        for (int k = 0; k < NUM_RO; k++) ro_data[k*DATA_W +: DATA_W] = m_ro[k];
        for (int k = 0; k < NUM_RW; k++) m_rw[k] = 32'h0;
        m_err = 0;

        repeat (3) @(negedge clk);
        check_output("reset_shift_data", jtag.shift_data_o, 32'h0);
        check_output("reset_strobe", 32'(wr_strobe), 32'h0);
        check_output("reset_err", 32'(err), 32'h0);
        trst = 1'b0;
        for (int k = 0; k < NUM_RW; k++)
            check_output("reset_rw", rw_data[k*DATA_W +: DATA_W], m_rw[k]);
        apply_stimulus_read(1, 1'b1);

        apply_stimulus_write(6, 32'h1234_5678, 1'b1, 1'b1, 1'b0);
        apply_stimulus_read(6, 1'b1);
        apply_stimulus_read(4, 1'b1);

        repeat (3) apply_stimulus_write(8'h40, $urandom, 1'b1, 1'b1, 1'b0);
        check_output("err_after_3", 32'(err), 32'h1);
        apply_stimulus_read(254, 1'b1);
        apply_stimulus_read(254, 1'b1);
        check_output("err_after_clear", 32'(err), 32'h0);

        for (int i = 0; i < 150; i++) begin
            logic sel, wr;
            sel = ($urandom_range(0, 7) != 0);
            wr  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 1) == 1) apply_stimulus_write(pick_addr(), $urandom, sel, wr, 1'b0);
            else                           apply_stimulus_read(pick_addr(), sel);
            check_output("err_o_random", 32'(err), 32'(m_err != 0));
        end

        apply_stimulus_read(254, 1'b1);
        repeat (300) apply_stimulus_write(8'h40, $urandom, 1'b1, 1'b1, 1'b0);
        apply_stimulus_read(254, 1'b1);
        apply_stimulus_read(254, 1'b1);
        check_output("err_after_sat_clear", 32'(err), 32'h0);

        // Abort an update in flight: the synchronised pulse must never appear.
        @(negedge clk);
        set_tcr(6, 1'b1, 1'b0);
        jtag.sel_i        = 1'b1;
        jtag.shift_data_i = 32'hCAFE_0001;
        jtag.update_dr_i  = 1'b1;
        @(negedge clk);
        trst = 1'b1;
        jtag.update_dr_i = 1'b0;
        for (int k = 0; k < NUM_RW; k++) m_rw[k] = 32'h0;
        m_err = 0;
        repeat (2) @(negedge clk);
        trst = 1'b0;
        repeat (8) @(negedge clk);
        check_output("midreset_rw0", rw_data[0 +: DATA_W], 32'h0);
        apply_stimulus_read(6, 1'b1);

`ifdef JTAG_REG_BRIDGE_AUTOINC_EN
        for (int k = 0; k < NUM_RW; k++) begin
            logic [31:0] d;
            d = $urandom;
            @(negedge clk);
            set_tcr(6, 1'b1, 1'b1);
            jtag.sel_i        = 1'b1;
            jtag.shift_data_i = d;
            m_rw[k] = d;
            wr_q.push_back('{idx: k, data: d});
            jtag.update_dr_i = 1'b1;
            repeat (4) @(negedge clk);
            jtag.update_dr_i = 1'b0;
            repeat (4) @(negedge clk);
        end
        apply_stimulus_write(0, 32'h0, 1'b0, 1'b0, 1'b0);
`endif

        repeat (10) @(negedge clk);
        check_output("pending_writes", 32'(wr_q.size()), 32'h0);
        check_output("pending_reads", 32'(rd_q.size()), 32'h0);
        for (int k = 0; k < NUM_RW; k++)
            check_output("final_rw", rw_data[k*DATA_W +: DATA_W], m_rw[k]);
        check_output("final_err", 32'(err), 32'(m_err != 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/jtag_reg_bridge.md
Name: jtag_reg_bridge

Overview:
- Parametrised JTAG-to-fabric register bridge, the successor to the hard-coded trcal_reg mux in the top-level wrapper.
- Sits in the clk domain between jtag_test_interface (tcr_out, trcal_tr_out, update_dr, capture_dr, extest_sel, all tck-domain) and user logic.
- Exposes NUM_RO read-only status words and NUM_RW read/write control words through one address-mapped window, with tck-to-clk pulse synchronisation and error counting.

Parameters:
- DATA_W, 32, JTAG shift register (TRCAL) width.
- CTRL_W, 32, JTAG control register (tcr) width; must be at least 10.
- NUM_RO, 4, number of read-only input words (1..120).
- NUM_RW, 4, number of read/write output words (1..120); NUM_RO+NUM_RW must be at most 252.
- ID_VALUE, 32'hDEAD_BEEF, constant returned at address 0x01.
- RW_RESET, 0, reset value of every RW word.
- BAD_VALUE, 32'hBEEF_BEEF, read value for unmapped addresses.
- ERR_W, 8, error counter width.

Ports:
- clk  in  1  fabric clock.
- trst  in  1  reset, asynchronous, active-high.
- update_dr_i  in  1  tck-domain Update-DR indication.
- capture_dr_i  in  1  tck-domain Capture-DR indication.
- sel_i  in  1  EXTEST instruction selected.
- tcr_i  in  CTRL_W  control register.
- shift_data_i  in  DATA_W  shift register contents (JTAG write data).
- shift_data_o  out  DATA_W  data presented for Capture-DR.
- ro_data_i  in  NUM_RO*DATA_W  read-only words; word k is at [k*DATA_W +: DATA_W].
- rw_data_o  out  NUM_RW*DATA_W  read/write words, same packing.
- wr_strobe_o  out  NUM_RW  one-clk pulse per RW word written.
- err_o  out  1  high while the error counter is non-zero.

Behaviour:
- Control field decode:
  - addr = tcr_i[CTRL_W-1 -: 8].
  - wr = tcr_i[CTRL_W-9].
  - autoinc = tcr_i[CTRL_W-10] (used only when the optional feature is enabled).
- Address map:
  - 0x00: reads zero.
  - 0x01: reads ID_VALUE.
  - 0x02 .. 0x02+NUM_RO-1: RO words.
  - next NUM_RW addresses: RW words.
  - 0xFE: reads the error counter, zero-extended; the counter clears on read.
  - All other addresses: read BAD_VALUE.
- Synchronisation:
  - update_dr_i and capture_dr_i each pass through a 2-flop synchroniser followed by a rising-edge detector, giving a one-clk pulse (upd_p, cap_p).
  - Pulse latency is 3 clk cycles from the input edge.
  - tck period must be at least 4 clk periods.
  - tcr_i and shift_data_i are treated as quasi-static; they are sampled only on upd_p.
- Read path:
  - shift_data_o is registered every clk cycle from the mux at the effective address.
  - Latency is 1 clk after an address or source change, so the value is stable well before Capture-DR at the tck-rate limit.
- Write, on upd_p with sel_i=1 and wr=1:
  - Effective address in the RW range: the word is loaded from shift_data_i on the next clk and the matching wr_strobe_o bit pulses high for exactly 1 clk in the same cycle.
  - Effective address at 0xFE: no write, not an error.
  - Any other effective address: no write; the error counter increments, saturating at all ones.
- Write, on upd_p with sel_i=0 or wr=0: no action.
- Clear-on-read, on cap_p with sel_i=1 and effective address 0xFE:
  - The counter clears one clk after shift_data_o has been loaded with the pre-clear value.
- Simultaneous error increment and clear in the same clk: the clear wins.
- upd_p and cap_p in the same clk are processed independently.
- Reset (trst=1, at any time including mid-transfer):
  - Synchroniser flops, edge-detect flops and pointer are cleared.
  - Error counter is cleared.
  - RW words are set to RW_RESET.
  - shift_data_o=0, wr_strobe_o=0, err_o=0.
  - Any in-flight pulse is dropped.

Optional Feature:
- JTAG_REG_BRIDGE_AUTOINC_EN defined:
  - An 8-bit pointer ptr is added; effective address = (addr + ptr) mod 256.
  - ptr increments after each upd_p while sel_i=1 and autoinc=1, including no-op and error writes.
  - ptr clears when autoinc=0, or when addr differs from the addr latched at the previous upd_p.
  - Wrap from 0xFF goes to 0x00.
- Undefined: effective address = addr; the autoinc bit is ignored; no pointer register exists.

Decomposition:
- jtag_reg_bridge_pkg holds:
  - Address constants ADDR_ZERO, ADDR_ID, ADDR_RO_BASE and ADDR_ERR.
  - Field offset functions for addr, wr and autoinc relative to CTRL_W.
  - An addr_t typedef (8-bit).
- One sub-module, jtag_pulse_sync (2-flop synchroniser plus rising-edge detect, asynchronous trst), instantiated twice.

Test Plan:
- Reset check: after trst, read address 0x01 -> shift_data_o=32'hDEAD_BEEF; all rw_data_o equal 0; err_o=0.
- RW write: write 32'h1234_5678 to address 0x06 (RW0 with NUM_RO=4) -> after the pulse, wr_strobe_o=4'b0001 for 1 clk, RW0=32'h1234_5678; reading address 0x06 returns the same value.
- RO read: ro_data_i word2=32'hA5A5_0003, address 0x04 -> shift_data_o=32'hA5A5_0003 one clk later.
- Error counting: write to 0x40 three times -> err_o=1; read 0xFE returns 3; a second read of 0xFE returns 0 and err_o=0.
- Saturation: 300 writes to 0x40 with ERR_W=8 -> counter reads 0xFF.
- Reset mid-transfer and autoinc: assert trst 1 clk after an update_dr_i edge -> no wr_strobe_o and RW0=RW_RESET. With AUTOINC_EN, autoinc=1 and addr=0x06, four writes -> RW0..RW3 loaded in order.
